// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority vote, framing check.
// Optional parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clk_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int H  = OVERSAMPLE / 2;
   localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] C_S0   = CW'(H - 1);
   localparam logic [CW-1:0] C_S1   = CW'(H);
   localparam logic [CW-1:0] C_DEC  = CW'(H + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, nstate;
   logic                 sync1, rx_s;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic                 v0, v1, ferr_i;
   logic [DATA_BITS-1:0] shreg;
   logic                 vote, dec, wrap, last_data, last_stop;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {rx_s, sync1} <= 2'b11;
      else        {rx_s, sync1} <= {sync1, rx};

   assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
   assign dec       = (cnt == C_DEC);
   assign wrap      = (cnt == C_LAST);
   assign last_data = (bit_idx == 4'(DATA_BITS - 1));
   assign last_stop = (bit_idx == 4'(STOP_BITS - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nstate;

   always_comb begin
      nstate = state;
      if (clk_en) begin
         unique case (state)
            IDLE:   if (!rx_s) nstate = START;
            START:  if (dec && vote) nstate = IDLE;
                    else if (wrap) nstate = DATA;
            DATA:   if (wrap && last_data)
`ifdef UART_RX_PARITY_EN
                       nstate = PARITY;
`else
                       nstate = STOP;
`endif
            PARITY: if (wrap) nstate = STOP;
            STOP:   if (dec && last_stop) nstate = IDLE;
            default: nstate = IDLE;
         endcase
      end
   end

   // The detecting strobe counts as cnt 0, so START begins counting at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bit_idx    <= '0;
         v0         <= 1'b1;
         v1         <= 1'b1;
         ferr_i     <= 1'b0;
         shreg      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (clk_en) begin
            if (cnt == C_S0) v0 <= rx_s;
            if (cnt == C_S1) v1 <= rx_s;
            if (nstate == IDLE)     cnt <= '0;
            else if (state == IDLE) cnt <= CW'(1);
            else if (wrap)          cnt <= '0;
            else                    cnt <= cnt + CW'(1);
            unique case (state)
               START: begin
                  ferr_i  <= 1'b0;
                  bit_idx <= '0;
               end
               DATA: begin
                  if (dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
                  if (wrap) bit_idx <= last_data ? 4'd0 : bit_idx + 4'd1;
               end
               STOP: begin
                  if (dec && !vote) ferr_i <= 1'b1;
                  if (dec && last_stop) begin
                     data       <= shreg;
                     frame_err  <= ferr_i | ~vote;
                     data_valid <= 1'b1;
                  end
                  if (wrap) bit_idx <= bit_idx + 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic perr_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perr_i     <= 1'b0;
         parity_err <= 1'b0;
      end else if (clk_en && dec) begin
         if (state == PARITY)
            perr_i <= vote ^ (^shreg) ^ 1'(PARITY_ODD);
         if (state == STOP && last_stop)
            parity_err <= perr_i;
      end
`else
   logic unused_par;
   assign unused_par = 1'(PARITY_ODD);
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: default 8N1 instance plus a 7-bit/2-stop/x8 instance,
// frames built as per-strobe line samples and checked against a queue model.
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clk_en;
   logic       rx_a, rx_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       dv_a, fe_a, pe_a, busy_a;
   logic       dv_b, fe_b, pe_b, busy_b;
   logic [1:0] en_cnt = 2'd0;
   int         tick = 0;

   always #5 clk = ~clk;
   always @(posedge clk) en_cnt <= en_cnt + 2'd1;
   assign clk_en = (en_cnt == 2'd3);
   always @(posedge clk) if (clk_en) tick <= tick + 1;

   uart_rx_os dut_a (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx(rx_a),
      .data(data_a), .data_valid(dv_a), .frame_err(fe_a),
      .parity_err(pe_a), .busy(busy_a)
   );

   uart_rx_os #(
      .DATA_BITS(7), .OVERSAMPLE(8), .STOP_BITS(2), .PARITY_ODD(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx(rx_b),
      .data(data_b), .data_valid(dv_b), .frame_err(fe_b),
      .parity_err(pe_b), .busy(busy_b)
   );

   typedef struct {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
      int         tick;
   } exp_t;

   typedef struct {
      int         sel;
      logic [8:0] w;
      logic       bstop;
      logic       bpar;
      int         spike;
      int         gap;
      logic [8:0] xd;
      logic       xfe;
      logic       xpe;
   } vec_t;

   exp_t qa[$], qb[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic pdv_a = 0, pdv_b = 0;
   logic [8:0] pd_a = 0, pd_b = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic mon(input int sel, input logic [8:0] d, input logic dv,
                      input logic fe, input logic pe, input logic pdv,
                      input logic [8:0] pd);
      exp_t e;
      logic have;
      if (dv) begin
         chk($sformatf("dv_width%0d", sel), pdv, 0);
         have = (sel != 0) ? (qb.size() > 0) : (qa.size() > 0);
         if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_dv%0d: got data %0h, required no pulse", sel, d);
         end else begin
            if (sel != 0) e = qb.pop_front();
            else          e = qa.pop_front();
            chk($sformatf("data%0d", sel), d, e.data);
            chk($sformatf("frame_err%0d", sel), fe, e.ferr);
            chk($sformatf("parity_err%0d", sel), pe, e.perr);
            chk($sformatf("dv_tick%0d", sel), tick, e.tick);
         end
      end else if (d != pd) begin
         chk($sformatf("data_hold%0d", sel), d, pd);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         mon(0, {1'b0, data_a}, dv_a, fe_a, pe_a, pdv_a, pd_a);
         mon(1, {2'b0, data_b}, dv_b, fe_b, pe_b, pdv_b, pd_b);
      end
      pdv_a = dv_a;
      pdv_b = dv_b;
      pd_a  = {1'b0, data_a};
      pd_b  = {2'b0, data_b};
   end

   task automatic wstrobe();
      @(negedge clk);
      while (!clk_en) @(negedge clk);
      @(posedge clk);
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel != 0) rx_b = v;
      else          rx_a = v;
   endtask

   task automatic idle(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         wstrobe();
         #1 drive(sel, 1'b1);
      end
   endtask

   // One line sample per strobe; frame = start, data LSB first, parity, stops.
   task automatic send(input int sel, input logic [8:0] w, input logic bstop,
                       input logic bpar, input int spike, input int abort_at,
                       input logic [8:0] xd, input logic xfe, input logic xpe);
      int   os, nb, ns, t0;
      logic p, v;
      logic bits[$];
      exp_t e;
      os = (sel != 0) ? 8 : 16;
      nb = (sel != 0) ? 7 : 8;
      ns = (sel != 0) ? 2 : 1;
      p  = (sel != 0);
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         bits.push_back(w[i]);
         p ^= w[i];
      end
      if (P == 1) bits.push_back(p ^ bpar);
      for (int s = 0; s < ns; s++) bits.push_back(!(bstop && s == ns - 1));
      for (int i = 0; i < bits.size() * os; i++) begin
         wstrobe();
         #1;
         if (i == 0) begin
            t0 = tick + 1;
            e.data = xd;
            e.ferr = xfe;
            e.perr = xpe;
            e.tick = t0 + (nb + P + ns) * os + os / 2 + 1;
            if (abort_at < 0) begin
               if (sel != 0) qb.push_back(e);
               else          qa.push_back(e);
            end
         end
         if (i == abort_at) return;
         v = bits[i / os];
         if (i == spike) v = ~v;
         drive(sel, v);
      end
   endtask

   initial begin
      #5_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic       pe1;
      logic [8:0] w;
      logic       bs, bp;
      int         t0, sel;
      pe1 = 1'(P);
      rx_a = 1'b1;
      rx_b = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_a", data_a, 0);
      chk("reset_dv_a", dv_a, 0);
      chk("reset_busy_a", busy_a, 0);
      chk("reset_fe_b", fe_b, 0);
      chk("reset_pe_b", pe_b, 0);
      rst_n = 1'b1;
      idle(0, 4);

      tbl.push_back('{0, 9'h055, 0, 0, -1,  0, 9'h055, 0, 0});
      tbl.push_back('{0, 9'h0A3, 0, 0, -1, 12, 9'h0A3, 0, 0});
      tbl.push_back('{0, 9'h00F, 0, 0, 56, 12, 9'h00F, 0, 0});
      tbl.push_back('{0, 9'h0A3, 1, 0, -1, 24, 9'h0A3, 1, 0});
      tbl.push_back('{0, 9'h007, 0, 0, -1, 12, 9'h007, 0, 0});
      tbl.push_back('{0, 9'h007, 0, 1, -1, 12, 9'h007, 0, pe1});
      tbl.push_back('{1, 9'h05A, 0, 0, -1,  0, 9'h05A, 0, 0});
      tbl.push_back('{1, 9'h021, 0, 0, -1, 12, 9'h021, 0, 0});
      tbl.push_back('{1, 9'h033, 1, 0, -1, 24, 9'h033, 1, 0});
      tbl.push_back('{1, 9'h007, 0, 0, -1, 12, 9'h007, 0, 0});
      tbl.push_back('{1, 9'h007, 0, 1, -1, 12, 9'h007, 0, pe1});

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].sel, tbl[i].w, tbl[i].bstop, tbl[i].bpar, tbl[i].spike,
              -1, tbl[i].xd, tbl[i].xfe, tbl[i].xpe);
         idle(tbl[i].sel, tbl[i].gap);
      end

      // start glitch: 4 low strobes must be rejected without output
      t0 = 0;
      for (int j = 0; j < 14; j++) begin
         wstrobe();
         #1;
         if (j == 0) t0 = tick + 1;
         rx_a = (j < 4) ? 1'b0 : 1'b1;
         if (tick == t0 + 1)  chk("glitch_busy_up", busy_a, 1);
         if (tick == t0 + 10) chk("glitch_busy_down", busy_a, 0);
      end
      send(0, 9'h03C, 0, 0, -1, -1, 9'h03C, 0, 0);
      idle(0, 8);

      // reset during data bit 4
      send(0, 9'h0C6, 0, 0, -1, 86, 9'h0C6, 0, 0);
      chk("busy_mid_frame", busy_a, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_data", data_a, 0);
      chk("rst_dv", dv_a, 0);
      chk("rst_fe", fe_a, 0);
      chk("rst_pe", pe_a, 0);
      chk("rst_busy", busy_a, 0);
      rx_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(0, 4);
      send(0, 9'h03C, 0, 0, -1, -1, 9'h03C, 0, 0);
      idle(0, 6);

      for (int i = 0; i < 32; i++) begin
         sel = (i < 16) ? 0 : 1;
         w  = 9'($urandom) & ((sel != 0) ? 9'h07F : 9'h0FF);
         bs = ($urandom_range(0, 7) == 0);
         bp = (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         send(sel, w, bs, bp, -1, -1, w, bs, bp);
         idle(sel, bs ? 24 : $urandom_range(0, 6));
      end

      idle(0, 40);
      chk("pending_a", qa.size(), 0);
      chk("pending_b", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver for the Tang Nano 9K UART path.
- Takes a baud-multiple sample strobe and recovers frames of configurable data width and stop-bit count.
- Majority-votes three mid-bit samples, rejects start-bit glitches, and flags framing errors; parity checking is optional.
- Sits between the rx pin and the byte consumer (command decoder/FIFO); the baud generator drives its strobe.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..9; sent LSB first.
- `OVERSAMPLE`, 16, `clk_en` strobes per bit period; even, 8..64.
- `STOP_BITS`, 1, number of stop bits checked; 1 or 2.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; used only with `UART_RX_PARITY_EN`.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_en` input 1: sample strobe at OVERSAMPLE × baud, one `clk` wide.
- `rx` input 1: serial line, asynchronous, idle high.
- `data` output DATA_BITS: last received word; held until the next `data_valid`.
- `data_valid` output 1: one-`clk` pulse, frame complete.
- `frame_err` output 1: qualified by `data_valid`; a stop bit was sampled 0.
- `parity_err` output 1: qualified by `data_valid`; parity mismatch (tied 0 without macro).
- `busy` output 1: high in any state other than IDLE.

## Operation
- **Input synchroniser:** `rx` passes through two flops every `clk` (reset value 1), giving `rx_s`. All other logic advances only on `clk_en`.
- **Counters:**
  - `cnt`, width $clog2(OVERSAMPLE), counts 0..OVERSAMPLE-1 and wraps.
  - `bit_idx` counts data bits.
  - H = OVERSAMPLE/2.
- **Majority vote:** `rx_s` is sampled at cnt = H-1, H and H+1. The bit value is the majority of the three and is decided at cnt = H+1.
- **States:**
  - IDLE: on a strobe with `rx_s` = 0, go to START with cnt = 0.
  - START: at the decision point, a voted 1 is a glitch; return to IDLE with no output. Otherwise continue to cnt = OVERSAMPLE-1, then go to DATA with cnt = 0 and bit_idx = 0.
  - DATA: at each decision, shift the voted bit in at the MSB (LSB-first frame). After bit DATA_BITS-1, wait for the cnt wrap, then go to PARITY if the macro is defined, else STOP.
  - PARITY: at the decision point, compare the voted bit with the XOR of the data bits, XOR PARITY_ODD. Go to STOP after the wrap.
  - STOP: decide each stop bit.
    - A voted 0 sets the internal frame error.
    - At the decision point of the last stop bit, load `data`, `frame_err` and `parity_err`, pulse `data_valid`, and go straight to IDLE. This allows resync in the second half of the stop bit.
    - With STOP_BITS = 2, the first stop bit wraps back into STOP.
- **Error handling:** a frame with errors is still delivered; `data` is updated.
- **Strobe gating:** while `clk_en` = 0, state, counters and shift register hold.
- **Reset:** assertion at any time, including mid-frame, forces the following immediately:
  - state IDLE, counters 0;
  - `data` = 0, `data_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0;
  - synchroniser flops = 1.

## Timing
- Tick T0 is the first strobe that sees `rx_s` = 0 (the line edge lags by 2–3 `clk` through the synchroniser).
- Data bit k is decided at tick T0 + (k+1)·OVERSAMPLE + H + 1.
- The last stop-bit decision is at tick T0 + (DATA_BITS + P + STOP_BITS)·OVERSAMPLE + H + 1, where P = 1 with the parity macro, else 0.
  - Default 8N1: T0 + 153.
- `data_valid` is asserted on the `clk` cycle after that strobe and is low at all other times. `data`, `frame_err` and `parity_err` change only in that cycle.
- Back-to-back frames with no idle gap are received without loss. The next start edge can be detected from tick T0 + 153 + 1.
- `busy` rises the cycle after T0 and falls with `data_valid`.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and one parity bit is expected after the data bits. `parity_err` reports a mismatch using PARITY_ODD.
- `UART_RX_PARITY_EN` undefined: no PARITY state and no parity bit in the frame. `parity_err` is constant 0 and PARITY_ODD is ignored.

## Test plan
- **Nominal 8N1:** defaults, `clk_en` every 4 `clk`, send 0x55 then 0xA3 → two `data_valid` pulses, each exactly 1 `clk`. `data` = 0x55 then 0xA3; `frame_err` = 0.
- **Start glitch:** `rx` low for 4 strobes, then high → no `data_valid`; `busy` returns to 0 by strobe T0+H+2. A following 0x3C is received correctly.
- **Noise and framing:** a one-strobe inverted spike at cnt = H in data bit 2 of 0x0F → `data` = 0x0F. Stop bit driven 0 for 0xA3 → `data` = 0xA3 with `frame_err` = 1.
- **Parity (macro on, even):** 0x07 with parity bit 1 → `parity_err` = 0. 0x07 with parity bit 0 → `parity_err` = 1. Repeat with PARITY_ODD = 1; the expectations are inverted.
- **Reset mid-frame:** pull `rst_n` low during data bit 4 → all outputs 0 immediately. After release, 0x3C arrives with `data_valid` and `data` = 0x3C.
- **Width and stop variants:** DATA_BITS = 7, STOP_BITS = 2, OVERSAMPLE = 8; send 0x5A back-to-back with 0x21 → `data` = 0x5A then 0x21, both `frame_err` = 0. A 0 in the second stop bit → `frame_err` = 1.
